// File: rtl/mux253_scan_ctrl.sv
// mux253_scan_ctrl: walks a 74LS253 dual 4:1 mux through all four select codes,
// samples Y1/Y2 at each code and rebuilds the two 4-bit input words in parallel.
// Optional macro MUX253_SCAN_CONTINUOUS_EN: start held in DONE restarts the scan
// directly, without passing through IDLE.
module mux253_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y1,
    input  logic       Y2,
    output logic       S0,
    output logic       S1,
    output logic       G1_n,
    output logic       G2_n,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic       busy,
    output logic       valid
);

    // Settle counter wide enough to hold SETTLE_CYCLES-1 (at least one bit).
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0] IDX_LAST = 2'd3;

    // A zero settle time would leave no cycle for the mux outputs to settle.
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("mux253_scan_ctrl: SETTLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Shadows fill from the top: after codes 0,1,2 bit i holds the sample of code i.
    logic [2:0]       sh1_q, sh1_d;
    logic [2:0]       sh2_q, sh2_d;
    logic [3:0]       q1_q, q1_d;
    logic [3:0]       q2_q, q2_d;
    logic [1:0]       sel_q, sel_d;
    logic             en_n_q, en_n_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;

    // State, datapath and registered outputs; async reset returns everything to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            sh1_q   <= 3'd0;
            sh2_q   <= 3'd0;
            q1_q    <= 4'd0;
            q2_q    <= 4'd0;
            sel_q   <= 2'd0;
            en_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            sel_q   <= sel_d;
            en_n_q  <= en_n_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic; output registers are derived from the next state so they
    // line up with the state they describe.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        q1_d    = q1_q;
        q2_d    = q2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (idx_q != IDX_LAST) begin
                    sh1_d   = {Y1, sh1_q[2:1]};
                    sh2_d   = {Y2, sh2_q[2:1]};
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SETTLE;
                end else begin
                    q1_d    = {Y1, sh1_q};
                    q2_d    = {Y2, sh2_q};
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
`ifdef MUX253_SCAN_CONTINUOUS_EN
                if (start) begin
                    state_d = ST_SETTLE;
                    idx_d   = 2'd0;
                    cnt_d   = CNT_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d  = (state_d != ST_IDLE);
        valid_d = (state_d == ST_DONE);
        en_n_d  = (state_d == ST_IDLE);
        sel_d   = (state_d == ST_IDLE) ? 2'd0 : idx_d;
    end

    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign G1_n  = en_n_q;
    assign G2_n  = en_n_q;
    assign Q1    = q1_q;
    assign Q2    = q2_q;
    assign busy  = busy_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_mux253_scan_ctrl.sv
// Directed bench for mux253_scan_ctrl with a behavioural 74LS253 model.
module tb_mux253_scan_ctrl;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic       start;
    logic       Y1;
    logic       Y2;
    logic       S0;
    logic       S1;
    logic       G1_n;
    logic       G2_n;
    logic [3:0] Q1;
    logic [3:0] Q2;
    logic       busy;
    logic       valid;

    logic [3:0] mux_d1;
    logic [3:0] mux_d2;
    logic [5:0] vec;

    int checks;
    int errors;

    mux253_scan_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .Y1    (Y1),
        .Y2    (Y2),
        .S0    (S0),
        .S1    (S1),
        .G1_n  (G1_n),
        .G2_n  (G2_n),
        .Q1    (Q1),
        .Q2    (Q2),
        .busy  (busy),
        .valid (valid)
    );

    // Mux model: a disabled section reads as 0.
    assign Y1 = G1_n ? 1'b0 : mux_d1[{S1, S0}];
    assign Y2 = G2_n ? 1'b0 : mux_d2[{S1, S0}];

    assign vec = {S1, S0, G1_n, G2_n, busy, valid};

    // Gated clock so reset can be applied with no edges present.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full scan from IDLE; restart_k >= 0 pulses start during that scan cycle.
    task automatic do_scan(input logic [3:0] d1, input logic [3:0] d2,
                           input logic [3:0] old1, input logic [3:0] old2,
                           input int restart_k);
        mux_d1 = d1;
        mux_d2 = d2;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("seq_k%0d", k), 32'(vec), 32'({2'(k / 3), 2'b00, 1'b1, 1'b0}));
            if (k == 11) chk("q_hold_pre_done", 32'({Q1, Q2}), 32'({old1, old2}));
            start = (k == restart_k);
            tick();
        end
        start = 1'b0;
        chk("done_vec", 32'(vec), 32'(6'b110011));
        chk("done_q", 32'({Q1, Q2}), 32'({d1, d2}));
        tick();
        chk("after_done_vec", 32'(vec), 32'(6'b001100));
    endtask

    initial begin
        int  n;
        bit  seen_g_high;
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst    = 1'b0;
        start  = 1'b0;
        mux_d1 = 4'b0000;
        mux_d2 = 4'b0000;

        // Reset applied with the clock stopped must act immediately.
        #2 rst = 1'b1;
        #1;
        chk("rst_async_vec", 32'(vec), 32'(6'b001100));
        chk("rst_async_q", 32'({Q1, Q2}), 32'h00);
        clk_en = 1'b1;
        repeat (3) tick();
        chk("rst_held_vec", 32'(vec), 32'(6'b001100));
        rst = 1'b0;
        tick();
        chk("idle_vec", 32'(vec), 32'(6'b001100));

        // Basic scan.
        do_scan(4'b0110, 4'b1001, 4'h0, 4'h0, -1);

        // start pulsed mid-scan is ignored.
        do_scan(4'b0110, 4'b1001, 4'b0110, 4'b1001, 3);
        tick();
        chk("no_extra_valid", 32'(vec), 32'(6'b001100));

        // Reset during SETTLE of code 2 abandons the scan and clears Q.
        mux_d1 = 4'b1111;
        mux_d2 = 4'b0000;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (6) tick();
        chk("pre_rst_sel", 32'(vec), 32'(6'b100010));
        rst = 1'b1;
        #1;
        chk("mid_rst_vec", 32'(vec), 32'(6'b001100));
        chk("mid_rst_q", 32'({Q1, Q2}), 32'h00);
        repeat (2) tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid) n++;
        end
        chk("no_valid_after_rst", 32'(n), 32'd0);
        chk("q_after_rst", 32'({Q1, Q2}), 32'h00);
        do_scan(4'b1111, 4'b0000, 4'h0, 4'h0, -1);

        // Q holds across IDLE while the mux data changes.
        do_scan(4'b0110, 4'b1001, 4'b1111, 4'b0000, -1);
        mux_d1 = 4'b1010;
        mux_d2 = 4'b0101;
        repeat (5) tick();
        chk("q_hold_idle", 32'({Q1, Q2}), 32'({4'b0110, 4'b1001}));
        do_scan(4'b1010, 4'b0101, 4'b0110, 4'b1001, -1);

        // start held high: spacing between valid pulses.
        start = 1'b1;
        n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        chk("first_valid_latency", 32'(n), 32'd13);
        n = 0;
        seen_g_high = 1'b0;
        do begin
            tick();
            n++;
            if (G1_n || G2_n) seen_g_high = 1'b1;
`ifdef MUX253_SCAN_CONTINUOUS_EN
            if (n == 1) chk("restart_vec", 32'(vec), 32'(6'b000010));
`else
            if (n == 1) chk("restart_vec", 32'(vec), 32'(6'b001100));
            if (n == 2) chk("restart_vec2", 32'(vec), 32'(6'b000010));
`endif
        end while (!valid && n < 40);
`ifdef MUX253_SCAN_CONTINUOUS_EN
        chk("valid_spacing", 32'(n), 32'd13);
        chk("enables_stay_low", 32'(seen_g_high), 32'd0);
`else
        chk("valid_spacing", 32'(n), 32'd14);
        chk("idle_gap_seen", 32'(seen_g_high), 32'd1);
`endif
        chk("cont_q", 32'({Q1, Q2}), 32'({4'b1010, 4'b0101}));
        start = 1'b0;
        repeat (20) tick();
        chk("final_idle", 32'(vec), 32'(6'b001100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
